// File: rtl/usbh_cfg_pkg.sv
// -----------------------------------------------------------------------------
// usbh_cfg_pkg
// Shared types and constants for the usbh_host configuration-port arbiter:
//   - cfg_state_e : transaction FSM states
//   - RESP_*      : AXI4-Lite response encodings
//   - cfg_req_t   : one requester's transaction descriptor
//   - resp_is_err : maps an AXI response code to the requester error flag
// -----------------------------------------------------------------------------
package usbh_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WRESP,
    RD,
    RRESP,
    DONE
  } cfg_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cfg_req_t;

  // SLVERR and DECERR are failures; OKAY and EXOKAY are not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/usbh_rr_arb2.sv
// -----------------------------------------------------------------------------
// usbh_rr_arb2
// Two-input round-robin arbiter. The grant is combinational from the request
// vector; the tie-break pointer moves only when a grant is actually taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : pending requests
//   en         : consumer can accept a grant this cycle
//   gnt[1:0]   : one-hot grant (zero when nothing is requested)
// -----------------------------------------------------------------------------
module usbh_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Set when req1 should win the next tie; clear out of reset so req0 goes first.
  logic prio1;

  always_comb begin
    // NOTE: gnt gets a default before any branch so no path can infer a latch.
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = prio1 ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio1 <= 1'b0;
    end else if (en && (req != 2'b00)) begin
      // NOTE: non-blocking so the flop takes the grant seen before this edge.
      prio1 <= gnt[0];
    end
  end

endmodule

// File: rtl/usbh_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// usbh_cfg_arbiter
// Shares the usbh_host AXI4-Lite configuration slave between the enumeration
// sequencer (req0) and the periodic poller (req1). One transaction is in
// flight at a time; a watchdog aborts any transaction whose slave stalls.
// Ports:
//   clk_i, rst_i        : 48 MHz USB clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata/wstrb_i : request from requester N
//   reqN_ready_o        : request accepted this cycle (combinational)
//   reqN_done_o/err_o   : one-cycle completion pulse and its error flag
//   reqN_rdata_o        : read data, held until the next completion for N
//   busy_o              : a transaction is in flight
//   cfg_*               : AXI4-Lite master toward usbh_host
// -----------------------------------------------------------------------------
module usbh_cfg_arbiter
  import usbh_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  input  logic        req0_write_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  input  logic [3:0]  req0_wstrb_i,
  output logic        req0_ready_o,
  output logic        req0_done_o,
  output logic [31:0] req0_rdata_o,
  output logic        req0_err_o,

  input  logic        req1_valid_i,
  input  logic        req1_write_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  input  logic [3:0]  req1_wstrb_i,
  output logic        req1_ready_o,
  output logic        req1_done_o,
  output logic [31:0] req1_rdata_o,
  output logic        req1_err_o,

  output logic        busy_o,

  output logic        cfg_awvalid_o,
  output logic [31:0] cfg_awaddr_o,
  output logic        cfg_wvalid_o,
  output logic [31:0] cfg_wdata_o,
  output logic [3:0]  cfg_wstrb_o,
  output logic        cfg_bready_o,
  output logic        cfg_arvalid_o,
  output logic [31:0] cfg_araddr_o,
  output logic        cfg_rready_o,

  input  logic        cfg_awready_i,
  input  logic        cfg_wready_i,
  input  logic        cfg_bvalid_i,
  input  logic [1:0]  cfg_bresp_i,
  input  logic        cfg_arready_i,
  input  logic        cfg_rvalid_i,
  input  logic [31:0] cfg_rdata_i,
  input  logic [1:0]  cfg_rresp_i
);

  // One spare bit so the counter can sit at the limit without wrapping.
  localparam int unsigned          CNT_W     = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  cfg_state_e       state;
  logic             owner;        // requester that holds the current grant
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_cnt_next;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic [31:0]      rdata_q [2];

  cfg_req_t         req [2];
  cfg_req_t         sel;
  logic [1:0]       gnt;
  logic             aw_pend;
  logic             w_pend;
  logic             step_done;
  logic             active;
  logic             abort_now;

  assign req[0] = '{write: req0_write_i, addr: req0_addr_i,
                    wdata: req0_wdata_i, wstrb: req0_wstrb_i};
  assign req[1] = '{write: req1_write_i, addr: req1_addr_i,
                    wdata: req1_wdata_i, wstrb: req1_wstrb_i};
  assign sel    = req[gnt[1]];

  usbh_rr_arb2 u_arb (
    .clk   (clk_i),
    .rst_n (rst_i),
    .req   ({req1_valid_i, req0_valid_i}),
    .en    (state == IDLE),
    .gnt   (gnt)
  );

  // Gated by reset so the ready outputs also read 0 while reset is held.
  assign req0_ready_o = rst_i && (state == IDLE) && gnt[0];
  assign req1_ready_o = rst_i && (state == IDLE) && gnt[1];
  assign busy_o       = (state != IDLE);

  assign req0_done_o  = done_q[0];
  assign req1_done_o  = done_q[1];
  assign req0_err_o   = err_q[0];
  assign req1_err_o   = err_q[1];
  assign req0_rdata_o = rdata_q[0];
  assign req1_rdata_o = rdata_q[1];

  // Address/data channels still waiting for their ready after this edge.
  assign aw_pend = cfg_awvalid_o && !cfg_awready_i;
  assign w_pend  = cfg_wvalid_o  && !cfg_wready_i;

  assign wd_cnt_next = wd_cnt + CNT_W'(1);
  assign active      = (state == WR) || (state == WRESP) ||
                       (state == RD) || (state == RRESP);

  // Progress that lets the current phase finish this cycle. Any progress
  // beats an expiring watchdog, so a response on the last cycle completes
  // normally.
  always_comb begin
    step_done = 1'b0;
    case (state)
      WR:      step_done = !aw_pend && !w_pend;
      WRESP:   step_done = cfg_bvalid_i;
      RD:      step_done = cfg_arready_i;
      RRESP:   step_done = cfg_rvalid_i;
      default: step_done = 1'b0;
    endcase
  end

  assign abort_now = active && (wd_cnt_next >= CNT_LIMIT) && !step_done;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      owner         <= 1'b0;
      wd_cnt        <= '0;
      done_q        <= 2'b00;
      err_q         <= 2'b00;
      // NOTE: the read-data holding registers drive outputs directly, so
      // they are reset like any other output flop.
      rdata_q[0]    <= '0;
      rdata_q[1]    <= '0;
      cfg_awvalid_o <= 1'b0;
      cfg_awaddr_o  <= '0;
      cfg_wvalid_o  <= 1'b0;
      cfg_wdata_o   <= '0;
      cfg_wstrb_o   <= '0;
      cfg_bready_o  <= 1'b0;
      cfg_arvalid_o <= 1'b0;
      cfg_araddr_o  <= '0;
      cfg_rready_o  <= 1'b0;
    end else begin
      done_q <= 2'b00;
      if (active) begin
        wd_cnt <= wd_cnt_next;
      end

      if (abort_now) begin
        // Dropping bready/rready here makes any late response invisible.
        state          <= DONE;
        cfg_awvalid_o  <= 1'b0;
        cfg_wvalid_o   <= 1'b0;
        cfg_bready_o   <= 1'b0;
        cfg_arvalid_o  <= 1'b0;
        cfg_rready_o   <= 1'b0;
        done_q[owner]  <= 1'b1;
        err_q[owner]   <= 1'b1;
        rdata_q[owner] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (gnt != 2'b00) begin
              owner  <= gnt[1];
              wd_cnt <= '0;
              if (sel.write) begin
                state         <= WR;
                cfg_awvalid_o <= 1'b1;
                cfg_wvalid_o  <= 1'b1;
                cfg_awaddr_o  <= sel.addr;
                cfg_wdata_o   <= sel.wdata;
                cfg_wstrb_o   <= sel.wstrb;
              end else begin
                state         <= RD;
                cfg_arvalid_o <= 1'b1;
                cfg_araddr_o  <= sel.addr;
              end
            end
          end

          WR: begin
            if (step_done) begin
              cfg_awvalid_o <= 1'b0;
              cfg_wvalid_o  <= 1'b0;
              cfg_bready_o  <= 1'b1;
              state         <= WRESP;
            end else begin
              // Each channel retires on its own ready.
              if (cfg_awready_i) cfg_awvalid_o <= 1'b0;
              if (cfg_wready_i)  cfg_wvalid_o  <= 1'b0;
            end
          end

          WRESP: begin
            if (cfg_bvalid_i) begin
              cfg_bready_o  <= 1'b0;
              state         <= DONE;
              done_q[owner] <= 1'b1;
              err_q[owner]  <= resp_is_err(cfg_bresp_i);
            end
          end

          RD: begin
            if (cfg_arready_i) begin
              cfg_arvalid_o <= 1'b0;
              cfg_rready_o  <= 1'b1;
              state         <= RRESP;
            end
          end

          RRESP: begin
            if (cfg_rvalid_i) begin
              cfg_rready_o   <= 1'b0;
              state          <= DONE;
              done_q[owner]  <= 1'b1;
              err_q[owner]   <= resp_is_err(cfg_rresp_i);
              rdata_q[owner] <= cfg_rdata_i;
            end
          end

          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usbh_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usbh_cfg_arbiter
// Directed bench for usbh_cfg_arbiter with a 16-cycle watchdog. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle 0 of each transaction is its grant cycle.
// -----------------------------------------------------------------------------
module tb_usbh_cfg_arbiter;
  import usbh_cfg_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;

  logic        req0_valid_i, req0_write_i;
  logic [31:0] req0_addr_i, req0_wdata_i;
  logic [3:0]  req0_wstrb_i;
  logic        req0_ready_o, req0_done_o, req0_err_o;
  logic [31:0] req0_rdata_o;

  logic        req1_valid_i, req1_write_i;
  logic [31:0] req1_addr_i, req1_wdata_i;
  logic [3:0]  req1_wstrb_i;
  logic        req1_ready_o, req1_done_o, req1_err_o;
  logic [31:0] req1_rdata_o;

  logic        busy_o;
  logic        cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, cfg_arvalid_o, cfg_rready_o;
  logic [31:0] cfg_awaddr_o, cfg_wdata_o, cfg_araddr_o;
  logic [3:0]  cfg_wstrb_o;

  logic        cfg_awready_i, cfg_wready_i, cfg_bvalid_i, cfg_arready_i, cfg_rvalid_i;
  logic [1:0]  cfg_bresp_i, cfg_rresp_i;
  logic [31:0] cfg_rdata_i;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  usbh_cfg_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req0_valid_i  (req0_valid_i),
    .req0_write_i  (req0_write_i),
    .req0_addr_i   (req0_addr_i),
    .req0_wdata_i  (req0_wdata_i),
    .req0_wstrb_i  (req0_wstrb_i),
    .req0_ready_o  (req0_ready_o),
    .req0_done_o   (req0_done_o),
    .req0_rdata_o  (req0_rdata_o),
    .req0_err_o    (req0_err_o),
    .req1_valid_i  (req1_valid_i),
    .req1_write_i  (req1_write_i),
    .req1_addr_i   (req1_addr_i),
    .req1_wdata_i  (req1_wdata_i),
    .req1_wstrb_i  (req1_wstrb_i),
    .req1_ready_o  (req1_ready_o),
    .req1_done_o   (req1_done_o),
    .req1_rdata_o  (req1_rdata_o),
    .req1_err_o    (req1_err_o),
    .busy_o        (busy_o),
    .cfg_awvalid_o (cfg_awvalid_o),
    .cfg_awaddr_o  (cfg_awaddr_o),
    .cfg_wvalid_o  (cfg_wvalid_o),
    .cfg_wdata_o   (cfg_wdata_o),
    .cfg_wstrb_o   (cfg_wstrb_o),
    .cfg_bready_o  (cfg_bready_o),
    .cfg_arvalid_o (cfg_arvalid_o),
    .cfg_araddr_o  (cfg_araddr_o),
    .cfg_rready_o  (cfg_rready_o),
    .cfg_awready_i (cfg_awready_i),
    .cfg_wready_i  (cfg_wready_i),
    .cfg_bvalid_i  (cfg_bvalid_i),
    .cfg_bresp_i   (cfg_bresp_i),
    .cfg_arready_i (cfg_arready_i),
    .cfg_rvalid_i  (cfg_rvalid_i),
    .cfg_rdata_i   (cfg_rdata_i),
    .cfg_rresp_i   (cfg_rresp_i)
  );

  // OR of every DUT output, and of just the AXI valids/readies.
  logic any_out, any_hs;
  assign any_hs  = |{cfg_awvalid_o, cfg_wvalid_o, cfg_bready_o, cfg_arvalid_o, cfg_rready_o};
  assign any_out = |{req0_ready_o, req0_done_o, req0_rdata_o, req0_err_o,
                     req1_ready_o, req1_done_o, req1_rdata_o, req1_err_o, busy_o,
                     cfg_awvalid_o, cfg_awaddr_o, cfg_wvalid_o, cfg_wdata_o,
                     cfg_wstrb_o, cfg_bready_o, cfg_arvalid_o, cfg_araddr_o, cfg_rready_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_i         = 1'b0;
    req0_valid_i  = 1'b0; req0_write_i = 1'b0; req0_addr_i = '0; req0_wdata_i = '0; req0_wstrb_i = '0;
    req1_valid_i  = 1'b0; req1_write_i = 1'b0; req1_addr_i = '0; req1_wdata_i = '0; req1_wstrb_i = '0;
    cfg_awready_i = 1'b0; cfg_wready_i = 1'b0; cfg_bvalid_i = 1'b0; cfg_bresp_i = RESP_OKAY;
    cfg_arready_i = 1'b0; cfg_rvalid_i = 1'b0; cfg_rdata_i = '0; cfg_rresp_i = RESP_OKAY;

    // ---- reset state ----
    repeat (2) cyc();
    smp();
    check("reset_all_outputs_zero", any_out, 0);
    cyc();
    rst_i = 1'b1;
    smp();
    check("post_reset_idle", busy_o, 0);

    // ---- req0 write 0x04 <= 0xDEADBEEF, zero-wait slave ----
    cyc();                                           // cycle 0
    req0_valid_i = 1'b1; req0_write_i = 1'b1; req0_addr_i = 32'h04;
    req0_wdata_i = 32'hDEADBEEF; req0_wstrb_i = 4'hF;
    cfg_awready_i = 1'b1; cfg_wready_i = 1'b1;
    smp();
    check("wr_ready0_c0", req0_ready_o, 1);
    check("wr_ready1_c0", req1_ready_o, 0);
    cyc();                                           // cycle 1
    req0_valid_i = 1'b0;
    smp();
    check("wr_awvalid_c1", cfg_awvalid_o, 1);
    check("wr_wvalid_c1", cfg_wvalid_o, 1);
    check("wr_awaddr_c1", cfg_awaddr_o, 32'h04);
    check("wr_wdata_c1", cfg_wdata_o, 32'hDEADBEEF);
    check("wr_wstrb_c1", cfg_wstrb_o, 4'hF);
    check("wr_busy_c1", busy_o, 1);
    cyc();                                           // cycle 2
    cfg_bvalid_i = 1'b1; cfg_bresp_i = RESP_OKAY;
    smp();
    check("wr_bready_c2", cfg_bready_o, 1);
    check("wr_awvalid_c2", cfg_awvalid_o, 0);
    check("wr_wvalid_c2", cfg_wvalid_o, 0);
    check("wr_done_c2", req0_done_o, 0);
    cyc();                                           // cycle 3
    cfg_bvalid_i = 1'b0;
    smp();
    check("wr_done_c3", req0_done_o, 1);
    check("wr_err_c3", req0_err_o, 0);
    check("wr_bready_c3", cfg_bready_o, 0);
    cyc();                                           // cycle 4
    smp();
    check("wr_done_c4", req0_done_o, 0);
    check("wr_busy_c4", busy_o, 0);

    // ---- req1 read 0x10, slave returns 0x12345678 with SLVERR ----
    cyc();                                           // cycle 0
    req1_valid_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'h10;
    cfg_arready_i = 1'b1;
    smp();
    check("rd_ready1_c0", req1_ready_o, 1);
    check("rd_ready0_c0", req0_ready_o, 0);
    cyc();                                           // cycle 1
    req1_valid_i = 1'b0;
    smp();
    check("rd_arvalid_c1", cfg_arvalid_o, 1);
    check("rd_araddr_c1", cfg_araddr_o, 32'h10);
    cyc();                                           // cycle 2
    cfg_rvalid_i = 1'b1; cfg_rdata_i = 32'h12345678; cfg_rresp_i = RESP_SLVERR;
    smp();
    check("rd_rready_c2", cfg_rready_o, 1);
    check("rd_arvalid_c2", cfg_arvalid_o, 0);
    cyc();                                           // cycle 3
    cfg_rvalid_i = 1'b0; cfg_rdata_i = '0; cfg_rresp_i = RESP_OKAY;
    smp();
    check("rd_done1_c3", req1_done_o, 1);
    check("rd_rdata1_c3", req1_rdata_o, 32'h12345678);
    check("rd_err1_c3", req1_err_o, 1);
    check("rd_done0_c3", req0_done_o, 0);
    cyc();                                           // cycle 4
    smp();
    check("rd_done1_c4", req1_done_o, 0);
    check("rd_rdata1_held", req1_rdata_o, 32'h12345678);

    // ---- both requesters reading back-to-back: grants 0,1,0,1 ----
    // Period of 8 cycles per pair: grant, RD, RRESP, DONE.
    req0_write_i = 1'b0; req0_addr_i = 32'h20;
    req1_write_i = 1'b0; req1_addr_i = 32'h24;
    for (int c = 0; c < 16; c++) begin
      cyc();
      req0_valid_i = (c <= 8);
      req1_valid_i = (c <= 12);
      cfg_arready_i = 1'b1;
      cfg_rvalid_i  = cfg_rready_o;
      cfg_rdata_i   = 32'hC0DE0000 + 32'(c);
      cfg_rresp_i   = RESP_OKAY;
      smp();
      check($sformatf("arb_ready0_c%0d", c), req0_ready_o, 32'((c % 8) == 0));
      check($sformatf("arb_ready1_c%0d", c), req1_ready_o, 32'((c % 8) == 4));
      check($sformatf("arb_ready_both_c%0d", c), req0_ready_o & req1_ready_o, 0);
      check($sformatf("arb_done0_c%0d", c), req0_done_o, 32'((c == 3) || (c == 11)));
      check($sformatf("arb_done1_c%0d", c), req1_done_o, 32'((c == 7) || (c == 15)));
      if (c == 3 || c == 11) begin
        check($sformatf("arb_rdata0_c%0d", c), req0_rdata_o, 32'hC0DE0000 + 32'(c - 1));
        check($sformatf("arb_err0_c%0d", c), req0_err_o, 0);
      end
      if (c == 7 || c == 15) begin
        check($sformatf("arb_rdata1_c%0d", c), req1_rdata_o, 32'hC0DE0000 + 32'(c - 1));
        check($sformatf("arb_err1_c%0d", c), req1_err_o, 0);
      end
    end
    cyc();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    cfg_arready_i = 1'b0; cfg_rvalid_i = 1'b0; cfg_rdata_i = '0;
    smp();
    check("arb_idle_after", busy_o, 0);

    // ---- req0 write: awready at cycle 1, wready at cycle 5 ----
    cyc();                                           // cycle 0
    req0_valid_i = 1'b1; req0_write_i = 1'b1; req0_addr_i = 32'h08;
    req0_wdata_i = 32'hCAFEF00D; req0_wstrb_i = 4'h3;
    smp();
    check("slow_ready0_c0", req0_ready_o, 1);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      req0_valid_i  = 1'b0;
      req0_wdata_i  = 32'h0;                         // DUT must hold its own copy
      cfg_awready_i = (c == 1);
      cfg_wready_i  = (c == 5);
      cfg_bvalid_i  = (c == 6);
      cfg_bresp_i   = RESP_OKAY;
      smp();
      check($sformatf("slow_awvalid_c%0d", c), cfg_awvalid_o, 32'(c == 1));
      check($sformatf("slow_wvalid_c%0d", c), cfg_wvalid_o, 32'(c <= 5));
      check($sformatf("slow_bready_c%0d", c), cfg_bready_o, 32'(c == 6));
      check($sformatf("slow_done0_c%0d", c), req0_done_o, 32'(c == 7));
      if (c <= 5) begin
        check($sformatf("slow_wdata_c%0d", c), cfg_wdata_o, 32'hCAFEF00D);
        check($sformatf("slow_wstrb_c%0d", c), cfg_wstrb_o, 4'h3);
      end
      if (c == 1) check("slow_awaddr_c1", cfg_awaddr_o, 32'h08);
      if (c == 7) check("slow_err0_c7", req0_err_o, 0);
    end
    cyc();
    cfg_awready_i = 1'b0; cfg_wready_i = 1'b0; cfg_bvalid_i = 1'b0;
    smp();
    check("slow_idle_after", busy_o, 0);

    // ---- req1 read, slave never responds: abort at grant+17 ----
    cyc();                                           // cycle 0
    req1_valid_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'h30;
    smp();
    check("to_ready1_c0", req1_ready_o, 1);
    for (int c = 1; c <= 18; c++) begin
      cyc();
      req1_valid_i  = 1'b0;
      // Late response after the abort: arready/rvalid offered, must be ignored.
      cfg_arready_i = (c >= 17);
      cfg_rvalid_i  = (c >= 17);
      cfg_rdata_i   = (c >= 17) ? 32'hFFFFFFFF : 32'h0;
      smp();
      check($sformatf("to_arvalid_c%0d", c), cfg_arvalid_o, 32'(c <= 16));
      check($sformatf("to_done1_c%0d", c), req1_done_o, 32'(c == 17));
      check($sformatf("to_busy_c%0d", c), busy_o, 32'(c <= 17));
      if (c == 17) begin
        check("to_err1_c17", req1_err_o, 1);
        check("to_rdata1_c17", req1_rdata_o, 0);
        check("to_handshakes_c17", any_hs, 0);
      end
      if (c == 18) begin
        check("to_rready_late_c18", cfg_rready_o, 0);
        check("to_rdata1_late_c18", req1_rdata_o, 0);
      end
    end
    cyc();
    cfg_arready_i = 1'b0; cfg_rvalid_i = 1'b0; cfg_rdata_i = '0;
    smp();
    check("to_no_second_done", req1_done_o, 0);

    // ---- req0 read, response lands on the expiry cycle: normal completion ----
    cyc();                                           // cycle 0
    req0_valid_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h40;
    smp();
    check("edge_ready0_c0", req0_ready_o, 1);
    for (int c = 1; c <= 17; c++) begin
      cyc();
      req0_valid_i  = 1'b0;
      cfg_arready_i = (c == 1);
      cfg_rvalid_i  = (c == 16);
      cfg_rdata_i   = (c == 16) ? 32'h55AA55AA : 32'h0;
      cfg_rresp_i   = RESP_OKAY;
      smp();
      check($sformatf("edge_rready_c%0d", c), cfg_rready_o, 32'((c >= 2) && (c <= 16)));
      check($sformatf("edge_done0_c%0d", c), req0_done_o, 32'(c == 17));
      if (c == 17) begin
        check("edge_err0_c17", req0_err_o, 0);
        check("edge_rdata0_c17", req0_rdata_o, 32'h55AA55AA);
      end
    end

    // ---- reset during WRESP, then req0 must win a tie ----
    cyc();                                           // idle cycle
    cfg_arready_i = 1'b0; cfg_rvalid_i = 1'b0; cfg_rdata_i = '0;
    cyc();                                           // cycle 0
    req0_valid_i = 1'b1; req0_write_i = 1'b1; req0_addr_i = 32'h0C;
    req0_wdata_i = 32'h0000A5A5; req0_wstrb_i = 4'hF;
    cfg_awready_i = 1'b1; cfg_wready_i = 1'b1;
    smp();
    check("rst_ready0_c0", req0_ready_o, 1);
    cyc();                                           // cycle 1
    req0_valid_i = 1'b0;
    cyc();                                           // cycle 2
    smp();
    check("rst_bready_c2", cfg_bready_o, 1);
    #1;
    rst_i = 1'b0;
    #1;
    check("rst_async_outputs_zero", any_out, 0);
    check("rst_async_rdata0", req0_rdata_o, 0);
    cyc();
    cfg_awready_i = 1'b0; cfg_wready_i = 1'b0;
    smp();
    check("rst_held_done0", req0_done_o, 0);
    check("rst_held_outputs_zero", any_out, 0);
    cyc();                                           // release, both valid
    rst_i = 1'b1;
    req0_valid_i = 1'b1; req0_write_i = 1'b0; req0_addr_i = 32'h50;
    req1_valid_i = 1'b1; req1_write_i = 1'b0; req1_addr_i = 32'h54;
    smp();
    check("rst_first_grant_ready0", req0_ready_o, 1);
    check("rst_first_grant_ready1", req1_ready_o, 0);
    check("rst_no_done0", req0_done_o, 0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      req0_valid_i  = 1'b0;
      req1_valid_i  = 1'b0;
      cfg_arready_i = 1'b1;
      cfg_rvalid_i  = cfg_rready_o;
      cfg_rdata_i   = 32'h0BADF00D;
      smp();
      check($sformatf("rst_done0_c%0d", c), req0_done_o, 32'(c == 3));
      check($sformatf("rst_done1_c%0d", c), req1_done_o, 0);
    end
    check("rst_rdata0_c3", req0_rdata_o, 32'h0BADF00D);
    cyc();
    cfg_arready_i = 1'b0; cfg_rvalid_i = 1'b0; cfg_rdata_i = '0;
    smp();
    check("final_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usbh_cfg_arbiter.md
Name: usbh_cfg_arbiter

Overview:
- Shares the usbh_host AXI4-Lite configuration slave port between two requesters: req0 is the init/enumeration sequencer and req1 is the periodic poller.
- Round-robin arbitration with one outstanding transaction at a time.
- Drives the AXI4-Lite master handshakes and returns read data and error status to the granted requester.
- Includes a response watchdog so a stalled slave cannot hang either requester.
- Sits in the 48 MHz USB clock domain, between the requesters and usbh_host cfg_*.

Parameters:
- TIMEOUT_CYCLES, 1023: max cycles from issue to final response before abort; must be ≥1.

Ports:
- clk_i  in  1  48 MHz USB clock
- rst_i  in  1  asynchronous, active-low reset
- reqN_valid_i  in  1  request pending (N=0,1); held until reqN_ready_o
- reqN_write_i  in  1  1=write, 0=read
- reqN_addr_i  in  32  register byte address
- reqN_wdata_i  in  32  write data
- reqN_wstrb_i  in  4  write byte strobes
- reqN_ready_o  out  1  request accepted this cycle
- reqN_done_o  out  1  one-cycle completion pulse
- reqN_rdata_o  out  32  read data; valid with done, held until next done for that N
- reqN_err_o  out  1  error flag; valid with done
- busy_o  out  1  transaction in flight
- cfg_awvalid_o/cfg_awaddr_o[31:0]/cfg_wvalid_o/cfg_wdata_o[31:0]/cfg_wstrb_o[3:0]/cfg_bready_o  out  AXI4-Lite write master
- cfg_arvalid_o/cfg_araddr_o[31:0]/cfg_rready_o  out  AXI4-Lite read master
- cfg_awready_i/cfg_wready_i/cfg_bvalid_i/cfg_bresp_i[1:0]/cfg_arready_i/cfg_rvalid_i/cfg_rdata_i[31:0]/cfg_rresp_i[1:0]  in  slave responses

Behaviour:
- Reset (async assert, sync release): every output 0, state IDLE, rr pointer selects req0 first, timeout counter 0.
- States and transitions:
  - IDLE: grant per rr, latch the request, go to WR or RD.
  - WR: awvalid and wvalid asserted together. Each drops independently once its ready is seen. When both are accepted, go to WRESP.
  - WRESP: bready=1. On bvalid, go to DONE with err=bresp[1].
  - RD: arvalid=1. On arready, go to RRESP.
  - RRESP: rready=1. On rvalid, capture rdata and err=rresp[1], go to DONE.
  - DONE: one cycle. reqN_done_o=1 for the granted N, then back to IDLE.
- Arbitration:
  - reqN_ready_o is combinational: state==IDLE and grant==N. Never both high.
  - Both valid: grant the one not granted last. Single valid: grant it regardless of the pointer.
  - Pointer updates on grant only.
- Latency with a zero-wait-state slave:
  - Write: ready at cycle 0, aw/w valid cycle 1, bvalid cycle 2, done cycle 3.
  - Read: ready cycle 0, arvalid cycle 1, rvalid cycle 2, done cycle 3.
- AXI outputs are registered. The address, data and strobes are driven from latched copies, stable while their valid is high. No valid drops before its ready.
- Watchdog:
  - Counter clears on grant and increments in WR/WRESP/RD/RRESP.
  - At TIMEOUT_CYCLES it forces DONE with err=1, rdata=0, and deasserts all cfg valids and readies.
  - A late slave response after abort is ignored, because bready/rready are 0.
- Simultaneous events:
  - A response arriving in the same cycle as timeout expiry wins; it is a normal completion.
  - awready and wready in the same cycle are allowed.
- Requesters may re-raise valid in the DONE cycle; the request is arbitrated in the following IDLE cycle. One idle cycle between transactions is mandatory.
- Reset mid-transaction: immediate abort and no done pulse. The slave is also reset by the same rst_i.
- busy_o = (state != IDLE).

Decomposition:
- Shared package usbh_cfg_pkg: state enum (IDLE, WR, WRESP, RD, RRESP, DONE), AXI resp constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), request struct {write, addr, wdata, wstrb}.
- One natural sub-module, usbh_rr_arb2: two-input round-robin grant with pointer register.

Test Plan:
- req0 write addr 0x04, wdata 0xDEADBEEF, wstrb 0xF, zero-wait slave:
  - req0_ready cycle 0; awaddr=0x04 and wdata captured cycle 1; req0_done cycle 3 with err=0.
- req1 read addr 0x10, slave rdata=0x12345678, rresp=2'b10:
  - req1_done with rdata=0x12345678, err=1.
- Both valid continuously for 4 transactions:
  - grant order 0,1,0,1; ready never coincident; exactly one idle cycle between dones.
- Write with awready at cycle 1 and wready at cycle 5:
  - awvalid low from cycle 2, wvalid held until cycle 5, wdata stable throughout; done after bvalid.
- Slave never responds, TIMEOUT_CYCLES=16:
  - done at grant+17 with err=1, rdata=0; all cfg valids/readies low after the abort.
- rst_i low during WRESP:
  - all outputs 0 asynchronously; no done pulse; after release, req0 wins the first grant.
